// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared types, defaults and sizing helper for the regfile_mp block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } regfile_state_e;

  localparam int unsigned DEF_REG_WIDTH = 32;
  localparam int unsigned DEF_NUM_REGS  = 32;

  // Smallest r such that 2**r >= value; a single register still needs one select bit.
  function automatic int unsigned CLOG2(input int unsigned value);
    int unsigned r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_if.sv
// ============================================================================
// Module  : regfile_if
// Brief   : Read, writeback, issue-scoreboard and status signals of regfile_mp.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_if #(
  parameter int unsigned AW           = 5,
  parameter int unsigned REG_WIDTH    = 32,
  parameter int unsigned NUM_RD_PORTS = 2
);

  logic                              Ready_o;
  logic [NUM_RD_PORTS*AW-1:0]        Rs_Sel_i;
  logic [NUM_RD_PORTS*REG_WIDTH-1:0] Rs_Data_o;
  logic [NUM_RD_PORTS-1:0]           Rs_Busy_o;
  logic                              Wr_We_i;
  logic [AW-1:0]                     Wr_Sel_i;
  logic [REG_WIDTH-1:0]              Wr_Data_i;
  logic                              Sb_Set_i;
  logic [AW-1:0]                     Sb_Sel_i;
  logic                              Flush_i;

  modport master (
    input  Ready_o, Rs_Data_o, Rs_Busy_o,
    output Rs_Sel_i, Wr_We_i, Wr_Sel_i, Wr_Data_i, Sb_Set_i, Sb_Sel_i, Flush_i
  );

  modport slave (
    output Ready_o, Rs_Data_o, Rs_Busy_o,
    input  Rs_Sel_i, Wr_We_i, Wr_Sel_i, Wr_Data_i, Sb_Set_i, Sb_Sel_i, Flush_i
  );

endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module  : regfile_scoreboard
// Brief   : Per-register busy bits with flush > set > clear priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned R0_IS_ZERO   = 1,
  localparam int unsigned AW          = CLOG2(NUM_REGS)
) (
  input  wire logic                       Clk_i,
  input  wire logic                       Rst_i,
  input  wire logic                       En_i,
  input  wire logic                       Clr_Valid_i,
  input  wire logic [AW-1:0]              Clr_Sel_i,
  input  wire logic                       Set_Valid_i,
  input  wire logic [AW-1:0]              Set_Sel_i,
  input  wire logic                       Flush_i,
  input  wire logic [NUM_RD_PORTS*AW-1:0] Rd_Sel_i,
  output logic      [NUM_RD_PORTS-1:0]    Rd_Busy_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (En_i) begin
      if (Flush_i) begin
        busy_d = '0;
      end else begin
        // Set is applied after clear so a new producer wins over a retiring one.
        if (Clr_Valid_i) busy_d[Clr_Sel_i] = 1'b0;
        if (Set_Valid_i) busy_d[Set_Sel_i] = 1'b1;
      end
    end
    if (R0_IS_ZERO != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_busy
    assign Rd_Busy_o[p] = busy_q[Rd_Sel_i[p*AW +: AW]];
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module  : regfile_mp
// Brief   : Multi-read-port register file with busy scoreboard and clear FSM.
//           Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned REG_WIDTH    = DEF_REG_WIDTH,
  parameter int unsigned NUM_REGS     = DEF_NUM_REGS,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned R0_IS_ZERO   = 1
) (
  input wire logic Clk_i,
  input wire logic Rst_i,
  regfile_if.slave bus_if
);

  localparam int unsigned AW = CLOG2(NUM_REGS);

  regfile_state_e          state_q, state_d;
  logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
  logic [REG_WIDTH-1:0]    regs_q [NUM_REGS];
  logic [NUM_RD_PORTS-1:0] sb_busy;
  logic                    ready;
  logic                    wr_r0;
  logic                    wr_en;

  assign ready          = (state_q == READY);
  assign wr_r0          = (R0_IS_ZERO != 0) && (bus_if.Wr_Sel_i == '0);
  assign wr_en          = ready & bus_if.Wr_We_i & ~wr_r0;
  assign bus_if.Ready_o = ready;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(NUM_REGS - 1)) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // The array has no reset of its own; the CLEAR walk zeroes it one entry per cycle.
  always_ff @(posedge Clk_i) begin
    if (!Rst_i) begin
      if (state_q == CLEAR) regs_q[clr_cnt_q] <= '0;
      else if (wr_en)       regs_q[bus_if.Wr_Sel_i] <= bus_if.Wr_Data_i;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .R0_IS_ZERO   (R0_IS_ZERO)
  ) u_scoreboard (
    .Clk_i       (Clk_i),
    .Rst_i       (Rst_i),
    .En_i        (ready),
    .Clr_Valid_i (wr_en),
    .Clr_Sel_i   (bus_if.Wr_Sel_i),
    .Set_Valid_i (bus_if.Sb_Set_i),
    .Set_Sel_i   (bus_if.Sb_Sel_i),
    .Flush_i     (bus_if.Flush_i),
    .Rd_Sel_i    (bus_if.Rs_Sel_i),
    .Rd_Busy_o   (sb_busy)
  );

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd_port
    logic [AW-1:0]        sel;
    logic [REG_WIDTH-1:0] data;
    logic                 busy;

    assign sel = bus_if.Rs_Sel_i[p*AW +: AW];

    always_comb begin
      data = regs_q[sel];
      busy = sb_busy[p];
      if ((R0_IS_ZERO != 0) && (sel == '0)) begin
        data = '0;
        busy = 1'b0;
      end
`ifdef REGFILE_BYPASS_EN
      else if (wr_en && (sel == bus_if.Wr_Sel_i)) begin
        data = bus_if.Wr_Data_i;
        busy = 1'b0;
      end
`endif
      if (!ready) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign bus_if.Rs_Data_o[p*REG_WIDTH +: REG_WIDTH] = data;
    assign bus_if.Rs_Busy_o[p]                        = busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module  : tb_regfile_mp
// Brief   : Self-checking bench for regfile_mp with a queue of expected reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  localparam int RW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_if #(.AW(AW), .REG_WIDTH(RW), .NUM_RD_PORTS(NP)) bus ();

  regfile_mp #(
    .REG_WIDTH    (RW),
    .NUM_REGS     (NR),
    .NUM_RD_PORTS (NP),
    .R0_IS_ZERO   (1)
  ) dut (
    .Clk_i  (clk),
    .Rst_i  (rst),
    .bus_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Each entry is {busy, data} expected on one read port.
  logic [RW:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Wr_We_i   = 1'b0;
    bus.Wr_Sel_i  = '0;
    bus.Wr_Data_i = '0;
    bus.Sb_Set_i  = 1'b0;
    bus.Sb_Sel_i  = '0;
    bus.Flush_i   = 1'b0;
  endtask

  task automatic sel2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.Rs_Sel_i = {a1, a0};
  endtask

  task automatic test_reset();
    logic [RW:0] got, exp;
    int cyc;
    rst = 1'b1;
    sel2(5'd1, 5'd2);
    tick();
    n_checks++;
    if (bus.Ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 0", bus.Ready_o);
    end
    rst = 1'b0;
    cyc = 0;
    while (bus.Ready_o !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 32) begin
      n_fail++;
      $display("FAIL clear_length: got %0d cycles required 32", cyc);
    end
    for (int r = 0; r < NR; r++) begin
      sel2(AW'(r), AW'(NR - 1 - r));
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      #1;
      for (int p = 0; p < NP; p++) begin
        got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL cleared_r%0d_p%0d: got %h required %h", r, p, got, exp);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic [RW:0] got, exp;
    sel2(5'd0, 5'd0);
    bus.Wr_We_i = 1'b1; bus.Wr_Sel_i = 5'd5; bus.Wr_Data_i = 32'hDEADBEEF;
    tick();
    idle();
    sel2(5'd5, 5'd5);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    #1;
    bus.Wr_We_i = 1'b1; bus.Wr_Sel_i = 5'd0; bus.Wr_Data_i = 32'h1234;
    tick();
    idle();
    bus.Wr_We_i = 1'b1; bus.Wr_Sel_i = 5'd31; bus.Wr_Data_i = 32'h0BADF00D;
    for (int p = 0; p < NP; p++) begin
      got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL x5_read_p%0d: got %h required %h", p, got, exp);
      end
    end
    tick();
    idle();
    sel2(5'd0, 5'd31);
    exp_q.push_back({1'b0, 32'h0});
    exp_q.push_back({1'b0, 32'h0BADF00D});
    #1;
    for (int p = 0; p < NP; p++) begin
      got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL x0_x31_p%0d: got %h required %h", p, got, exp);
      end
    end
  endtask

  task automatic test_scoreboard();
    logic [RW:0] got, exp;
    sel2(5'd0, 5'd0);
    bus.Sb_Set_i = 1'b1; bus.Sb_Sel_i = 5'd7;
    tick();
    idle();
    sel2(5'd7, 5'd7);
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    #1;
    for (int p = 0; p < NP; p++) begin
      got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL x7_set_p%0d: got %h required %h", p, got, exp);
      end
    end
    sel2(5'd0, 5'd0);
    bus.Wr_We_i = 1'b1; bus.Wr_Sel_i = 5'd7; bus.Wr_Data_i = 32'h77;
    bus.Sb_Set_i = 1'b1; bus.Sb_Sel_i = 5'd7;
    tick();
    idle();
    sel2(5'd7, 5'd7);
    exp_q.push_back({1'b1, 32'h77});
    #1;
    got = {bus.Rs_Busy_o[0], bus.Rs_Data_o[0 +: RW]};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL x7_set_wins: got %h required %h", got, exp);
    end
    sel2(5'd0, 5'd0);
    bus.Wr_We_i = 1'b1; bus.Wr_Sel_i = 5'd7; bus.Wr_Data_i = 32'h78;
    tick();
    bus.Wr_We_i = 1'b0;
    bus.Sb_Set_i = 1'b1; bus.Sb_Sel_i = 5'd0;
    tick();
    idle();
    sel2(5'd7, 5'd0);
    exp_q.push_back({1'b0, 32'h78});
    exp_q.push_back({1'b0, 32'h0});
    #1;
    for (int p = 0; p < NP; p++) begin
      got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL x7_clear_x0_set_p%0d: got %h required %h", p, got, exp);
      end
    end
  endtask

  task automatic test_flush();
    logic [RW:0] got, exp;
    bus.Sb_Set_i = 1'b1; bus.Sb_Sel_i = 5'd3;
    tick();
    bus.Sb_Sel_i = 5'd9;
    tick();
    idle();
    sel2(5'd3, 5'd9);
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
    #1;
    for (int p = 0; p < NP; p++) begin
      got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL busy_before_flush_p%0d: got %h required %h", p, got, exp);
      end
    end
    bus.Flush_i = 1'b1; bus.Sb_Set_i = 1'b1; bus.Sb_Sel_i = 5'd4;
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      if (k == 0) sel2(5'd3, 5'd9);
      else        sel2(5'd4, 5'd4);
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      #1;
      for (int p = 0; p < NP; p++) begin
        got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL after_flush_%0d_p%0d: got %h required %h", k, p, got, exp);
        end
      end
    end
  endtask

  task automatic test_bypass();
    logic [RW:0] got, exp;
    bus.Sb_Set_i = 1'b1; bus.Sb_Sel_i = 5'd10;
    tick();
    idle();
    bus.Wr_We_i = 1'b1; bus.Wr_Sel_i = 5'd10; bus.Wr_Data_i = 32'hA5;
    sel2(5'd10, 5'd10);
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back({1'b0, 32'hA5});
    exp_q.push_back({1'b0, 32'hA5});
`else
    exp_q.push_back({1'b1, 32'h0});
    exp_q.push_back({1'b1, 32'h0});
`endif
    #1;
    for (int p = 0; p < NP; p++) begin
      got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL x10_same_cycle_p%0d: got %h required %h", p, got, exp);
      end
    end
    exp_q.push_back({1'b0, 32'hA5});
    tick();
    idle();
    got = {bus.Rs_Busy_o[1], bus.Rs_Data_o[RW +: RW]};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL x10_next_cycle: got %h required %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [RW:0] got, exp;
    int k;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (k = 1; k <= 100; k++) begin
      if (k == 31) begin
        bus.Wr_We_i = 1'b1; bus.Wr_Sel_i = 5'd2; bus.Wr_Data_i = 32'h99;
        bus.Sb_Set_i = 1'b1; bus.Sb_Sel_i = 5'd6;
      end
      tick();
      idle();
      if (bus.Ready_o === 1'b1) break;
    end
    n_checks++;
    if (k != 32) begin
      n_fail++;
      $display("FAIL restart_clear_length: got %0d cycles required 32", k);
    end
    for (int j = 0; j < 2; j++) begin
      if (j == 0) sel2(5'd2, 5'd6);
      else        sel2(5'd5, 5'd10);
      exp_q.push_back({1'b0, 32'h0});
      exp_q.push_back({1'b0, 32'h0});
      #1;
      for (int p = 0; p < NP; p++) begin
        got = {bus.Rs_Busy_o[p], bus.Rs_Data_o[p*RW +: RW]};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL post_restart_%0d_p%0d: got %h required %h", j, p, got, exp);
        end
      end
    end
  endtask

  initial begin
    idle();
    bus.Rs_Sel_i = '0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
